// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-add / multiply / accumulate slice.
// Optional input, product and output registers. Frames of ACC_LEN valid
// samples are summed and reported with a single-cycle OUT_VALID pulse,
// with optional saturation and a per-frame overflow flag.
module dsp_mac_pipe #(
    parameter int    AW       = 18,
    parameter int    BW       = 18,
    parameter int    PW       = 48,
    parameter int    INREG    = 1,
    parameter int    MREG     = 1,
    parameter int    PREG     = 1,
    parameter string PREADD   = "ADD",
    parameter int    ACC_LEN  = 16,
    parameter int    SATURATE = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CE,
    input  logic                        CLR,
    input  logic                        IN_VALID,
    input  logic [AW-1:0]               A,
    input  logic [BW-1:0]               B,
    input  logic [BW-1:0]               D,
    output logic                        OUT_VALID,
    output logic [PW-1:0]               P,
    output logic                        OVF,
    output logic [$clog2(ACC_LEN):0]    SAMPLE_CNT
);

    localparam int CW       = $clog2(ACC_LEN) + 1;
    localparam int MW       = AW + BW + 1;
    localparam int PRE_MODE = (PREADD == "ADD") ? 1 : ((PREADD == "SUB") ? 2 : 0);
    localparam logic [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

    logic signed [AW-1:0] a_r;
    logic signed [BW-1:0] b_r;
    logic signed [BW-1:0] d_r;
    logic                 v_r;
    logic signed [BW:0]   pre;
    logic signed [MW-1:0] prod_c;
    logic signed [MW-1:0] m_prod;
    logic                 m_v;

    logic signed [PW-1:0] prod_ext;
    logic signed [PW-1:0] acc;
    logic signed [PW-1:0] acc_base;
    logic signed [PW-1:0] sum;
    logic signed [PW-1:0] acc_next;
    logic [CW-1:0]        cnt;
    logic                 sticky;
    logic                 sticky_next;
    logic                 ovf_c;
    logic                 last;
    logic [PW-1:0]        f_p;
    logic                 f_v;
    logic                 f_ovf;

    generate
        if (INREG != 0) begin : g_inreg
            // Capture operands; a sample arriving with CLR is dropped here.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    a_r <= '0;
                    b_r <= '0;
                    d_r <= '0;
                    v_r <= 1'b0;
                end else if (CE) begin
                    a_r <= A;
                    b_r <= B;
                    d_r <= D;
                    v_r <= IN_VALID & ~CLR;
                end
            end
        end else begin : g_noinreg
            // Operands pass straight through to the pre-adder.
            always_comb begin
                a_r = A;
                b_r = B;
                d_r = D;
                v_r = IN_VALID & ~CLR;
            end
        end
    endgenerate

    // Pre-adder (one extra bit of headroom) followed by the signed multiply.
    always_comb begin
        case (PRE_MODE)
            1:       pre = {d_r[BW-1], d_r} + {b_r[BW-1], b_r};
            2:       pre = {d_r[BW-1], d_r} - {b_r[BW-1], b_r};
            default: pre = {b_r[BW-1], b_r};
        endcase
        prod_c = MW'(a_r) * MW'(pre);
    end

    generate
        if (MREG != 0) begin : g_mreg
            // Product register; CLR kills the in-flight valid.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    m_prod <= '0;
                    m_v    <= 1'b0;
                end else if (CE) begin
                    m_prod <= prod_c;
                    m_v    <= v_r & ~CLR;
                end
            end
        end else begin : g_nomreg
            // Product feeds the accumulator directly.
            always_comb begin
                m_prod = prod_c;
                m_v    = v_r;
            end
        end
    endgenerate

    assign prod_ext = PW'(m_prod);
    assign last     = (cnt == CW'(ACC_LEN - 1));

    // Next accumulator value: a frame starts from zero, overflow is a
    // same-sign add whose result flips sign.
    always_comb begin
        acc_base    = (cnt == '0) ? '0 : acc;
        sum         = acc_base + prod_ext;
        ovf_c       = (acc_base[PW-1] == prod_ext[PW-1]) && (sum[PW-1] != acc_base[PW-1]);
        acc_next    = sum;
        if (ovf_c && (SATURATE != 0)) begin
            acc_next = acc_base[PW-1] ? SAT_MIN : SAT_MAX;
        end
        sticky_next = ((cnt == '0) ? 1'b0 : sticky) | ovf_c;
    end

    // Accumulate stage; the frame result and its pulse leave on the last sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            f_p    <= '0;
            f_v    <= 1'b0;
            f_ovf  <= 1'b0;
        end else if (CE) begin
            if (CLR) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
                f_v    <= 1'b0;
            end else begin
                f_v <= 1'b0;
                if (m_v) begin
                    acc    <= acc_next;
                    sticky <= sticky_next;
                    if (last) begin
                        cnt   <= '0;
                        f_p   <= acc_next;
                        f_ovf <= sticky_next;
                        f_v   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

    generate
        if (PREG != 0) begin : g_preg
            // Output register; CLR drops a pending pulse but keeps P and OVF.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    P         <= '0;
                    OUT_VALID <= 1'b0;
                    OVF       <= 1'b0;
                end else if (CE) begin
                    if (CLR) begin
                        OUT_VALID <= 1'b0;
                    end else begin
                        P         <= f_p;
                        OUT_VALID <= f_v;
                        OVF       <= f_ovf;
                    end
                end
            end
        end else begin : g_nopreg
            // Outputs come straight from the accumulate-stage registers.
            always_comb begin
                P         = f_p;
                OUT_VALID = f_v;
                OVF       = f_ovf;
            end
        end
    endgenerate

    assign SAMPLE_CNT = cnt;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: five differently configured slices
// share clock/reset/CE/CLR and operand buses, each with its own valid.
module tb_dsp_mac_pipe;

    logic        CLK, RST, CE, CLR;
    logic [17:0] a_s, b_s, d_s;
    logic [4:0]  vin, ovs, ovfs;
    logic [47:0] p0, p1, p4;
    logic [17:0] p2, p3;
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;
    logic [3:0]  cnt2, cnt3;
    logic [0:0]  cnt4;

    int errs = 0;
    int chks = 0;
    int cyc = 0;
    int last_beat = 0;

    typedef struct {int k; longint p; bit o; int t;} ev_t;
    ev_t    evq[$];
    ev_t    mon_e;
    bit     mon_en;
    longint rp[$];
    bit     ro[$];
    int     rt[$];
    longint ep[$];
    bit     eo[$];
    longint sa[$], sb[$], sd[$];

    dsp_mac_pipe #(.ACC_LEN(4)) u0 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(vin[0]),
        .A(a_s), .B(b_s), .D(d_s), .OUT_VALID(ovs[0]), .P(p0), .OVF(ovfs[0]), .SAMPLE_CNT(cnt0));

    dsp_mac_pipe #(.PREADD("SUB"), .ACC_LEN(2), .INREG(0), .MREG(1), .PREG(0)) u1 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(vin[1]),
        .A(a_s), .B(b_s), .D(d_s), .OUT_VALID(ovs[1]), .P(p1), .OVF(ovfs[1]), .SAMPLE_CNT(cnt1));

    dsp_mac_pipe #(.AW(8), .BW(8), .PW(18), .ACC_LEN(8), .SATURATE(1)) u2 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(vin[2]),
        .A(a_s[7:0]), .B(b_s[7:0]), .D(d_s[7:0]), .OUT_VALID(ovs[2]), .P(p2), .OVF(ovfs[2]), .SAMPLE_CNT(cnt2));

    dsp_mac_pipe #(.AW(8), .BW(8), .PW(18), .ACC_LEN(8), .SATURATE(0), .MREG(0)) u3 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(vin[3]),
        .A(a_s[7:0]), .B(b_s[7:0]), .D(d_s[7:0]), .OUT_VALID(ovs[3]), .P(p3), .OVF(ovfs[3]), .SAMPLE_CNT(cnt3));

    dsp_mac_pipe #(.PREADD("NONE"), .ACC_LEN(1), .INREG(0), .MREG(0), .PREG(1)) u4 (
        .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .IN_VALID(vin[4]),
        .A(a_s), .B(b_s), .D(d_s), .OUT_VALID(ovs[4]), .P(p4), .OVF(ovfs[4]), .SAMPLE_CNT(cnt4));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic longint pval(input int k);
        case (k)
            0:       return longint'($signed(p0));
            1:       return longint'($signed(p1));
            2:       return longint'($signed(p2));
            3:       return longint'($signed(p3));
            default: return longint'($signed(p4));
        endcase
    endfunction

    // Record every OUT_VALID seen after an enabled edge, with its cycle number.
    always @(posedge CLK) begin
        mon_en = CE;
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            for (int k = 0; k < 5; k++) begin
                if (ovs[k]) begin
                    mon_e.k = k;
                    mon_e.p = pval(k);
                    mon_e.o = ovfs[k];
                    mon_e.t = cyc;
                    evq.push_back(mon_e);
                end
            end
        end
    end

    function automatic void pick(input int k);
        rp.delete(); ro.delete(); rt.delete();
        foreach (evq[i]) begin
            if (evq[i].k == k) begin
                rp.push_back(evq[i].p);
                ro.push_back(evq[i].o);
                rt.push_back(evq[i].t);
            end
        end
    endfunction

    function automatic longint rnd(input int w);
        longint v;
        v = longint'($urandom) & ((64'sd1 <<< w) - 1);
        if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    // Frame sums straight from the arithmetic: exact add, then clamp or wrap
    // whenever the running sum leaves the PW-bit signed range.
    function automatic void model(input int pw, input int mode, input int alen, input bit sat);
        longint lim, acc, pre;
        int     n;
        bit     st;
        ep.delete(); eo.delete();
        lim = 64'sd1 <<< (pw - 1);
        acc = 0; n = 0; st = 0;
        for (int i = 0; i < sa.size(); i++) begin
            pre = (mode == 1) ? sd[i] + sb[i] : (mode == 2) ? sd[i] - sb[i] : sb[i];
            if (n == 0) begin acc = 0; st = 0; end
            acc = acc + sa[i] * pre;
            if (acc > lim - 1) begin
                st = 1;
                acc = sat ? lim - 1 : acc - 2 * lim;
            end else if (acc < -lim) begin
                st = 1;
                acc = sat ? -lim : acc + 2 * lim;
            end
            n++;
            if (n == alen) begin
                ep.push_back(acc);
                eo.push_back(st);
                n = 0;
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic beat(input logic [4:0] m, input longint a, input longint b, input longint d);
        a_s = a[17:0];
        b_s = b[17:0];
        d_s = d[17:0];
        vin = m;
        last_beat = cyc;
        @(posedge CLK);
        #1;
        vin = '0;
    endtask

    task automatic send_q(input logic [4:0] m, input int maxgap);
        for (int i = 0; i < sa.size(); i++) begin
            beat(m, sa[i], sb[i], sd[i]);
            idle($urandom_range(maxgap, 0));
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; CE = 1'b1; CLR = 1'b0; vin = '0;
        idle(2);
        RST = 1'b0;
        evq.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1; CE = 1'b0; CLR = 1'b0; vin = '1;
        a_s = 18'h155; b_s = 18'h2AA; d_s = 18'h0F0;
        idle(2);
        chks++; if (ovs !== 5'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 00000", ovs); end
        chks++; if (p0 !== 48'd0) begin errs++; $display("FAIL reset_p0: got %0d expected 0", p0); end
        chks++; if (p2 !== 18'd0) begin errs++; $display("FAIL reset_p2: got %0d expected 0", p2); end
        chks++; if (ovfs !== 5'b0) begin errs++; $display("FAIL reset_ovf: got %b expected 00000", ovfs); end
        chks++; if (cnt0 !== 3'd0 || cnt2 !== 4'd0) begin errs++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt2); end
        vin = '0; RST = 1'b0; CE = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        do_reset();
        repeat (4) beat(5'b00001, 3, 5, 2);
        idle(8);
        pick(0);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL basic_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != 84) begin errs++; $display("FAIL basic_p: got %0d expected 84", rp[0]); end
            chks++; if (ro[0] != 1'b0) begin errs++; $display("FAIL basic_ovf: got %0d expected 0", ro[0]); end
            chks++; if (rt[0] - last_beat != 4) begin errs++; $display("FAIL basic_latency: got %0d expected 4", rt[0] - last_beat); end
        end
        chks++; if (cnt0 !== 3'd0) begin errs++; $display("FAIL basic_cnt: got %0d expected 0", cnt0); end
    endtask

    task automatic test_sub();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            beat(5'b00010, -2, 100, 0);
            idle(pass * 3);
            beat(5'b00010, 7, -1, 10);
            idle(6);
            pick(1);
            chks++; if (rp.size() != 1) begin errs++; $display("FAIL sub_pulses[%0d]: got %0d expected 1", pass, rp.size()); end
            if (rp.size() >= 1) begin
                chks++; if (rp[0] != 277) begin errs++; $display("FAIL sub_p[%0d]: got %0d expected 277", pass, rp[0]); end
                chks++; if (rt[0] - last_beat != 2) begin errs++; $display("FAIL sub_latency[%0d]: got %0d expected 2", pass, rt[0] - last_beat); end
            end
        end
    endtask

    task automatic test_sat();
        do_reset();
        repeat (8) beat(5'b01100, 127, 127, 127);
        idle(8);
        pick(2);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL sat_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != 131071 || ro[0] != 1'b1) begin errs++; $display("FAIL sat_clamp: got %0d ovf %0d expected 131071 ovf 1", rp[0], ro[0]); end
            chks++; if (rt[0] - last_beat != 4) begin errs++; $display("FAIL sat_latency: got %0d expected 4", rt[0] - last_beat); end
        end
        pick(3);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL wrap_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != -4080 || ro[0] != 1'b1) begin errs++; $display("FAIL wrap_value: got %0d ovf %0d expected -4080 ovf 1", rp[0], ro[0]); end
            chks++; if (rt[0] - last_beat != 3) begin errs++; $display("FAIL wrap_latency: got %0d expected 3", rt[0] - last_beat); end
        end
        // small frame after an overflowing one: flag must drop
        evq.delete(); sa.delete(); sb.delete(); sd.delete();
        for (int i = 0; i < 8; i++) begin
            sa.push_back(rnd(3)); sb.push_back(rnd(3)); sd.push_back(rnd(3));
        end
        send_q(5'b01100, 0);
        idle(8);
        model(18, 1, 8, 1);
        pick(2);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL small_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != ep[0] || ro[0] != 1'b0) begin errs++; $display("FAIL small_frame: got %0d ovf %0d expected %0d ovf 0", rp[0], ro[0], ep[0]); end
        end
        // random full-range frames in both overflow modes
        evq.delete(); sa.delete(); sb.delete(); sd.delete();
        for (int i = 0; i < 24; i++) begin
            sa.push_back(rnd(8)); sb.push_back(rnd(8)); sd.push_back(rnd(8));
        end
        send_q(5'b01100, 1);
        idle(8);
        for (int k = 2; k < 4; k++) begin
            model(18, 1, 8, k == 2);
            pick(k);
            chks++; if (rp.size() != ep.size()) begin errs++; $display("FAIL rand_sat_count[u%0d]: got %0d expected %0d", k, rp.size(), ep.size()); end
            for (int i = 0; i < rp.size() && i < ep.size(); i++) begin
                chks++;
                if (rp[i] != ep[i] || ro[i] != eo[i]) begin
                    errs++; $display("FAIL rand_sat[u%0d][%0d]: got %0d ovf %0d expected %0d ovf %0d", k, i, rp[i], ro[i], ep[i], eo[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit found;
        do_reset();
        sa.delete(); sb.delete(); sd.delete();
        for (int i = 0; i < 4; i++) begin
            sa.push_back(rnd(18)); sb.push_back(rnd(18)); sd.push_back(rnd(18));
        end
        model(48, 1, 4, 0);
        beat(5'b00001, sa[0], sb[0], sd[0]);
        beat(5'b00001, sa[1], sb[1], sd[1]);
        CE = 1'b0; idle(5); CE = 1'b1;
        beat(5'b00001, sa[2], sb[2], sd[2]);
        beat(5'b00001, sa[3], sb[3], sd[3]);
        idle(1);
        CE = 1'b0; idle(5); CE = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(1);
            if (ovs[0]) found = 1;
        end
        chks++; if (!found) begin errs++; $display("FAIL stall_timeout: got no OUT_VALID expected one within 40 cycles"); end
        CE = 1'b0; idle(5);
        chks++; if (ovs[0] !== 1'b1) begin errs++; $display("FAIL stall_pulse_held: got %0d expected 1", ovs[0]); end
        CE = 1'b1; idle(1);
        chks++; if (ovs[0] !== 1'b0) begin errs++; $display("FAIL stall_pulse_drop: got %0d expected 0", ovs[0]); end
        idle(4);
        pick(0);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL stall_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != ep[0]) begin errs++; $display("FAIL stall_p: got %0d expected %0d", rp[0], ep[0]); end
            chks++; if (rt[0] - last_beat != 9) begin errs++; $display("FAIL stall_latency: got %0d expected 9", rt[0] - last_beat); end
        end
    endtask

    task automatic test_clr();
        do_reset();
        repeat (4) beat(5'b00001, 3, 5, 2);
        idle(6);
        repeat (2) beat(5'b00001, 2, 2, 3);
        CLR = 1'b1;
        beat(5'b00001, 100, 1, 1);
        CLR = 1'b0;
        chks++; if (p0 !== 48'd84 || ovs[0] !== 1'b0) begin errs++; $display("FAIL clr_hold: got P %0d valid %0d expected P 84 valid 0", p0, ovs[0]); end
        idle(4);
        chks++; if (cnt0 !== 3'd0) begin errs++; $display("FAIL clr_inflight: got cnt %0d expected 0", cnt0); end
        evq.delete();
        repeat (4) beat(5'b00001, 2, 2, 3);
        idle(8);
        pick(0);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL clr_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != 40 || rt[0] - last_beat != 4) begin errs++; $display("FAIL clr_frame: got P %0d latency %0d expected P 40 latency 4", rp[0], rt[0] - last_beat); end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        repeat (4) beat(5'b00001, 3, 5, 2);
        idle(6);
        repeat (2) beat(5'b00001, 2, 2, 3);
        idle(3);
        chks++; if (cnt0 !== 3'd2) begin errs++; $display("FAIL midframe_cnt: got %0d expected 2", cnt0); end
        RST = 1'b1; idle(1); RST = 1'b0;
        chks++; if (p0 !== 48'd0 || cnt0 !== 3'd0) begin errs++; $display("FAIL rst_mid_clear: got P %0d cnt %0d expected 0 0", p0, cnt0); end
        evq.delete();
        repeat (4) beat(5'b00001, 2, 2, 3);
        idle(2);
        chks++; if (p0 !== 48'd0 || ovs[0] !== 1'b0) begin errs++; $display("FAIL rst_p_before: got P %0d valid %0d expected 0 0", p0, ovs[0]); end
        idle(6);
        pick(0);
        chks++; if (rp.size() != 1) begin errs++; $display("FAIL rst_pulses: got %0d expected 1", rp.size()); end
        if (rp.size() >= 1) begin
            chks++; if (rp[0] != 40 || rt[0] - last_beat != 4) begin errs++; $display("FAIL rst_frame: got P %0d latency %0d expected P 40 latency 4", rp[0], rt[0] - last_beat); end
        end
    endtask

    task automatic test_acc1();
        do_reset();
        beat(5'b10000, 1, 5, rnd(18));
        beat(5'b10000, 1, 6, rnd(18));
        beat(5'b10000, 1, 7, rnd(18));
        idle(6);
        pick(4);
        chks++; if (rp.size() != 3) begin errs++; $display("FAIL acc1_pulses: got %0d expected 3", rp.size()); end
        for (int i = 0; i < rp.size() && i < 3; i++) begin
            chks++;
            if (rp[i] != 5 + i || rt[i] != rt[0] + i) begin
                errs++; $display("FAIL acc1[%0d]: got P %0d at +%0d expected P %0d at +%0d", i, rp[i], rt[i] - rt[0], 5 + i, i);
            end
        end
        if (rp.size() == 3) begin
            chks++; if (rt[2] - last_beat != 2) begin errs++; $display("FAIL acc1_latency: got %0d expected 2", rt[2] - last_beat); end
        end
    endtask

    task automatic test_random();
        do_reset();
        sa.delete(); sb.delete(); sd.delete();
        for (int i = 0; i < 22; i++) begin
            sa.push_back(rnd(18)); sb.push_back(rnd(18)); sd.push_back(rnd(18));
        end
        send_q(5'b00011, 2);
        idle(10);
        for (int k = 0; k < 2; k++) begin
            model(48, k + 1, 4 - 2 * k, 0);
            pick(k);
            chks++; if (rp.size() != ep.size()) begin errs++; $display("FAIL rand_count[u%0d]: got %0d expected %0d", k, rp.size(), ep.size()); end
            for (int i = 0; i < rp.size() && i < ep.size(); i++) begin
                chks++;
                if (rp[i] != ep[i] || ro[i] != eo[i]) begin
                    errs++; $display("FAIL rand[u%0d][%0d]: got %0d ovf %0d expected %0d ovf %0d", k, i, rp[i], ro[i], ep[i], eo[i]);
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1; CE = 1'b0; CLR = 1'b0; vin = '0;
        a_s = '0; b_s = '0; d_s = '0;
        #1;
        test_reset();
        test_basic();
        test_sub();
        test_sat();
        test_stall();
        test_clr();
        test_rst_mid();
        test_acc1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
